// File: rtl/bcd_disp_pkg.sv
// Shared segment constants and the BCD-to-7-segment decode used by the display mux.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Codes 10..15 are not BCD; show a dash so a bad upstream count is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-high pattern {g,f,e,d,c,b,a}.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed 7-segment driver: shadows N BCD digits on load and scans one digit
// per refresh period onto registered seg/an/digit_idx outputs, with leading-zero blanking.
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic [(N_DIGITS > 1 ? $clog2(N_DIGITS) : 1)-1:0] digit_idx
);

  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam bit ACT_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]          SEG_OFF = ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF  = ACT_LOW ? '1 : '0;

  logic [4*N_DIGITS-1:0] shadow_reg;
  logic [PRESC_W-1:0]    presc_reg, presc_next;
  logic [IDX_W-1:0]      idx_reg, idx_next, digit_idx_reg;
  logic [6:0]            seg_reg, seg_next;
  logic [N_DIGITS-1:0]   an_reg, an_next;
  logic                  tick;

  logic [3:0]            digit_arr [N_DIGITS];
  logic [N_DIGITS-1:0]   zero_from;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [6:0]            dec_seg, seg_hot;
  logic [N_DIGITS-1:0]   an_hot;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign digit_arr[gi] = shadow_reg[4*gi +: 4];
  end

  // Prescaler and scan index
  assign tick = (presc_reg == PRESC_W'(REFRESH_DIV - 1));

  always_comb begin
    presc_next = tick ? '0 : presc_reg + 1'b1;
    idx_next   = idx_reg;
    if (tick) begin
      idx_next = (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end
  end

  // zero_from[k]: digit k and every digit above it are 0 (invalid codes are non-zero).
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run          = run & (digit_arr[k] == 4'h0);
      zero_from[k] = run;
    end
  end

  assign cur_digit = digit_arr[idx_reg];
  assign cur_blank = blank_lz && (idx_reg != '0) && zero_from[idx_reg];

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    seg_hot  = cur_blank ? SEG_BLANK : dec_seg;
    an_hot   = N_DIGITS'(1) << idx_reg;
    seg_next = ACT_LOW ? ~seg_hot : seg_hot;
    an_next  = ACT_LOW ? ~an_hot : an_hot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg    <= '0;
      presc_reg     <= '0;
      idx_reg       <= '0;
      digit_idx_reg <= '0;
      seg_reg       <= SEG_OFF;
      an_reg        <= AN_OFF;
    end else begin
      presc_reg     <= presc_next;
      idx_reg       <= idx_next;
      if (load) begin
        shadow_reg <= digits_in;
      end
      digit_idx_reg <= idx_reg;
      seg_reg       <= seg_next;
      an_reg        <= an_next;
    end
  end

  assign seg       = seg_reg;
  assign an        = an_reg;
  assign digit_idx = digit_idx_reg;

endmodule
